// File: rtl/countdown_timer_async_resetn_pkg.sv
// Shared definitions for the countdown timer.
// State encoding and default width shared with the up-counter family.
package countdown_timer_async_resetn_pkg;

    localparam int CNT_WIDTH = 10;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

endpackage

// File: rtl/countdown_timer_async_resetn.sv
// Loadable down counter with terminal-count pulse.
// Halts at zero or auto-reloads from the last loaded value.
module countdown_timer_async_resetn
    import countdown_timer_async_resetn_pkg::*;
#(
    parameter int               WIDTH          = CNT_WIDTH,
    parameter logic [WIDTH-1:0] RELOAD_DEFAULT = 10'h3FF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             tc_pulse,
    output logic             busy
);

    state_e           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic             r_tc;

    state_e           w_state_nxt;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] w_reload_nxt;
    logic             w_tc_nxt;
    logic             w_is_zero;
    logic             w_is_one;

    assign w_is_zero = (r_count == '0);
    assign w_is_one  = (r_count == WIDTH'(1));

    // State, count, reload and pulse registers; reset is asynchronous.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= ST_RUN;
            r_count  <= RELOAD_DEFAULT;
            r_reload <= RELOAD_DEFAULT;
            r_tc     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_reload <= w_reload_nxt;
            r_tc     <= w_tc_nxt;
        end
    end

    // Next-state logic: load wins, then countdown / reload / halt.
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_reload_nxt = r_reload;
        w_tc_nxt     = 1'b0;
        if (load) begin
            w_count_nxt  = load_value;
            w_reload_nxt = load_value;
            if (load_value == '0 && !auto_reload) begin
                w_state_nxt = ST_HALT;
            end else begin
                w_state_nxt = ST_RUN;
            end
        end else if (r_state == ST_RUN) begin
            if (w_is_zero && !auto_reload) begin
                // Reload was dropped while parked at zero.
                w_state_nxt = ST_HALT;
            end else if (enable) begin
                if (w_is_zero) begin
                    w_count_nxt = r_reload;
                end else if (w_is_one) begin
                    w_count_nxt = '0;
                    w_tc_nxt    = 1'b1;
                    if (!auto_reload) begin
                        w_state_nxt = ST_HALT;
                    end
                end else begin
                    w_count_nxt = r_count - WIDTH'(1);
                end
            end
        end
    end

    // Output decode: zero follows count directly, busy follows state.
    always_comb begin
        count    = r_count;
        zero     = w_is_zero;
        tc_pulse = r_tc;
        busy     = (r_state == ST_RUN);
    end

endmodule

// File: tb/tb_countdown_timer_async_resetn.sv
// Directed-vector bench for countdown_timer_async_resetn.
// Inputs change and outputs are sampled 1 time unit after posedge.
module tb_countdown_timer_async_resetn;

    localparam int W = 10;

    logic         clk;
    logic         resetn;
    logic         load;
    logic [W-1:0] load_value;
    logic         enable;
    logic         auto_reload;
    logic [W-1:0] count;
    logic         zero;
    logic         tc_pulse;
    logic         busy;

    int n_vec;
    int n_err;

    countdown_timer_async_resetn dut (
        .clk         (clk),
        .resetn      (resetn),
        .load        (load),
        .load_value  (load_value),
        .enable      (enable),
        .auto_reload (auto_reload),
        .count       (count),
        .zero        (zero),
        .tc_pulse    (tc_pulse),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check count, tc_pulse, busy and zero in one go.
    task automatic chk_all(input string tag, input logic [W-1:0] c,
                           input logic t, input logic b);
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".tc"}, 32'(tc_pulse), 32'(t));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".zero"}, 32'(zero), 32'(c == '0));
    endtask

    task automatic do_load(input logic [W-1:0] v);
        load       = 1'b1;
        load_value = v;
        step();
        load       = 1'b0;
    endtask

    logic [W-1:0] seq3 [7];
    logic         tc3  [7];

    initial begin
        n_vec       = 0;
        n_err       = 0;
        resetn      = 1'b0;
        load        = 1'b0;
        load_value  = '0;
        enable      = 1'b0;
        auto_reload = 1'b0;

        // 1: reset released mid-cycle, then async reset mid-count
        #12 resetn = 1'b1;
        #1 chk_all("rst", 10'h3FF, 1'b0, 1'b1);
        step();
        do_load(10'h200);
        chk_all("ld200", 10'h200, 1'b0, 1'b1);
        #2 resetn = 1'b0;
        #1 chk_all("arst", 10'h3FF, 1'b0, 1'b1);
        #1 resetn = 1'b1;
        step();
        chk_all("arst_hold", 10'h3FF, 1'b0, 1'b1);

        // 2: one-shot from 3
        enable      = 1'b1;
        auto_reload = 1'b0;
        do_load(10'd3);
        chk_all("os3", 10'd3, 1'b0, 1'b1);
        step(); chk_all("os2", 10'd2, 1'b0, 1'b1);
        step(); chk_all("os1", 10'd1, 1'b0, 1'b1);
        step(); chk_all("os0", 10'd0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(); chk_all("os_halt", 10'd0, 1'b0, 1'b0);
        end

        // 3: auto-reload period 3
        auto_reload = 1'b1;
        do_load(10'd2);
        chk_all("ar_ld", 10'd2, 1'b0, 1'b1);
        seq3 = '{10'd1, 10'd0, 10'd2, 10'd1, 10'd0, 10'd2, 10'd1};
        tc3  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            step(); chk_all("ar_seq", seq3[i], tc3[i], 1'b1);
        end

        // 4: enable gating
        auto_reload = 1'b0;
        enable      = 1'b1;
        do_load(10'd5);
        chk_all("en5", 10'd5, 1'b0, 1'b1);
        step(); chk_all("en_a", 10'd4, 1'b0, 1'b1);
        enable = 1'b0;
        step(); chk_all("en_b", 10'd4, 1'b0, 1'b1);
        step(); chk_all("en_c", 10'd4, 1'b0, 1'b1);
        enable = 1'b1;
        step(); chk_all("en_d", 10'd3, 1'b0, 1'b1);

        // 5: load beats terminal decrement, then load of zero
        do_load(10'd2);
        step(); chk_all("pl1", 10'd1, 1'b0, 1'b1);
        do_load(10'd7);
        chk_all("pl7", 10'd7, 1'b0, 1'b1);
        enable = 1'b0;
        do_load(10'd0);
        chk_all("pl0", 10'd0, 1'b0, 1'b0);

        // 6: drop auto_reload while parked at zero
        enable      = 1'b1;
        auto_reload = 1'b1;
        do_load(10'd1);
        chk_all("dr1", 10'd1, 1'b0, 1'b1);
        step(); chk_all("dr0", 10'd0, 1'b1, 1'b1);
        enable      = 1'b0;
        auto_reload = 1'b0;
        step(); chk_all("dr_halt", 10'd0, 1'b0, 1'b0);
        enable      = 1'b1;
        auto_reload = 1'b1;
        step(); chk_all("dr_stay", 10'd0, 1'b0, 1'b0);
        do_load(10'd4);
        chk_all("dr_ld4", 10'd4, 1'b0, 1'b1);
        step(); chk_all("dr3", 10'd3, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
